oven_heat_controller: RTL and testbench

//  Sequences a bake cycle for the oven temperature model: drives the heat level and

---
 rtl/oven_heat_controller.sv | 208 ++++++++++++++++++++
 tb/tb_oven_heat_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oven_heat_controller.sv
// oven_heat_controller
// Bake-cycle sequencer for the oven temperature model: start -> preheat to
// target -> timed bake -> done alarm -> idle. Drives a registered heat level
// (0..3) from the error between the latched target and the measured temperature.
//
// Optional feature: define OVEN_DOOR_INTERLOCK_EN to add a door_open input.
// While the door is open in PREHEAT/BAKE the heat is forced off, seconds ticks
// are ignored and the state is held; a start with the door open is rejected.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a valid start; heat off
// PRE   | heating toward tgt_out until the model reports preheated
// BAKE  | regulating temperature, counting time_left down on ticks
// DONE  | buzzer on for DONE_SECS ticks, heat off, then back to IDLE

module oven_heat_controller #(
    parameter int TEMP_W    = 10,
    parameter int TIME_W    = 12,
    parameter int MIN_TEMP  = 150,
    parameter int MAX_TEMP  = 500,
    parameter int FAST_BAND = 20,
    parameter int SLOW_BAND = 5,
    parameter int DONE_SECS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cancel,
    input  logic [TEMP_W-1:0] target_temp,
    input  logic [TIME_W-1:0] bake_time,
    input  logic              tick_1hz,
    input  logic [TEMP_W-1:0] current_temp,
    input  logic              preheated,
`ifdef OVEN_DOOR_INTERLOCK_EN
    input  logic              door_open,
`endif
    output logic [1:0]        heat,
    output logic [TEMP_W-1:0] tgt_out,
    output logic [1:0]        state,
    output logic [TIME_W-1:0] time_left,
    output logic              busy,
    output logic              done,
    output logic              buzzer,
    output logic              start_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREHEAT = 2'd1,
        S_BAKE    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int CNT_W = (DONE_SECS < 2) ? 1 : $clog2(DONE_SECS + 1);

    localparam logic [TEMP_W-1:0]        MIN_T    = TEMP_W'(MIN_TEMP);
    localparam logic [TEMP_W-1:0]        MAX_T    = TEMP_W'(MAX_TEMP);
    localparam logic signed [TEMP_W:0]   FAST_E   = (TEMP_W+1)'(FAST_BAND);
    localparam logic signed [TEMP_W:0]   SLOW_E   = (TEMP_W+1)'(SLOW_BAND);
    localparam logic signed [TEMP_W:0]   ZERO_E   = '0;
    localparam logic [CNT_W-1:0]         DONE_CNT = CNT_W'(DONE_SECS);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [TIME_W-1:0]        LEFT_ONE = TIME_W'(1);

    state_t              state_q, state_d;
    logic [1:0]          heat_q, heat_d;
    logic [TEMP_W-1:0]   tgt_q, tgt_d;
    logic [TIME_W-1:0]   left_q, left_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                door_hold;
    logic                start_ok;
    logic signed [TEMP_W:0] temp_err;
    logic [1:0]          heat_level;
    logic                regulating_now;
    logic                regulating_next;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign door_hold = door_open;
`else
    assign door_hold = 1'b0;
`endif

    assign start_ok = (target_temp >= MIN_T) && (target_temp <= MAX_T) &&
                      (bake_time != '0) && !door_hold;

    // Signed error: a temperature above target gives a negative value (heat off).
    assign temp_err = $signed({1'b0, tgt_q}) - $signed({1'b0, current_temp});

    // Heat level bands from the temperature error.
    always_comb begin
        heat_level = 2'd0;
        if (temp_err > FAST_E) begin
            heat_level = 2'd3;
        end else if (temp_err > SLOW_E) begin
            heat_level = 2'd2;
        end else if (temp_err > ZERO_E) begin
            heat_level = 2'd1;
        end
    end

    // Next-state, timer and pulse logic; priority cancel > start > tick.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (cancel) begin
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                left_d  = '0;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            tgt_d   = target_temp;
                            left_d  = bake_time;
                            state_d = S_PREHEAT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_PREHEAT: begin
                    if (!door_hold && preheated) begin
                        state_d = S_BAKE;
                    end
                end
                S_BAKE: begin
                    if (!door_hold && tick_1hz) begin
                        left_d = left_q - LEFT_ONE;
                        if (left_q == LEFT_ONE) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            cnt_d   = DONE_CNT;
                        end
                    end
                end
                S_DONE: begin
                    if (tick_1hz) begin
                        if (cnt_q <= CNT_ONE) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Heat is only driven while regulating now and after this edge, so it
    // drops to 0 on the same edge that enters IDLE or DONE.
    assign regulating_now  = (state_q == S_PREHEAT) || (state_q == S_BAKE);
    assign regulating_next = (state_d == S_PREHEAT) || (state_d == S_BAKE);

    // Registered heat command.
    always_comb begin
        heat_d = 2'd0;
        if (regulating_now && regulating_next && !door_hold) begin
            heat_d = heat_level;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            heat_q  <= 2'd0;
            tgt_q   <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            heat_q  <= heat_d;
            tgt_q   <= tgt_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign heat      = heat_q;
    assign tgt_out   = tgt_q;
    assign state     = state_q;
    assign time_left = left_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign buzzer    = (state_q == S_DONE);
    assign start_err = err_q;

endmodule

// File: tb/tb_oven_heat_controller.sv
// Bench for oven_heat_controller: a directed vector table, a bounded wait on
// the done pulse, an optional door-interlock sequence, and a randomized run
// checked against a cycle-level behavioural model.

module tb_oven_heat_controller;

    localparam int DONE_SECS = 3;

    logic        clk = 1'b0;
    logic        rst, start, cancel, tick_1hz, preheated, door_open;
    logic [9:0]  target_temp, current_temp;
    logic [11:0] bake_time;
    logic [1:0]  heat, state;
    logic [9:0]  tgt_out;
    logic [11:0] time_left;
    logic        busy, done, buzzer, start_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oven_heat_controller dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel),
        .target_temp(target_temp), .bake_time(bake_time), .tick_1hz(tick_1hz),
        .current_temp(current_temp), .preheated(preheated),
`ifdef OVEN_DOOR_INTERLOCK_EN
        .door_open(door_open),
`endif
        .heat(heat), .tgt_out(tgt_out), .state(state), .time_left(time_left),
        .busy(busy), .done(done), .buzzer(buzzer), .start_err(start_err)
    );

    typedef struct {
        bit r, s, c, t, p;
        int tg, bk, cu;
        int es, eh, el, et;
        bit eb, ed, ez, ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit s, bit c, bit t, bit p, int tg, int bk, int cu,
                                int es, int eh, int el, int et, bit eb, bit ed, bit ez, bit ee);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.t = t; v.p = p;
        v.tg = tg; v.bk = bk; v.cu = cu;
        v.es = es; v.eh = eh; v.el = el; v.et = et;
        v.eb = eb; v.ed = ed; v.ez = ez; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input bit r, input bit s, input bit c, input bit t, input bit p,
                         input bit d, input int tg, input int bk, input int cu);
        rst = r; start = s; cancel = c; tick_1hz = t; preheated = p; door_open = d;
        target_temp = 10'(tg); bake_time = 12'(bk); current_temp = 10'(cu);
    endtask

    task automatic check(input string name, input int es, input int eh, input int el, input int et,
                         input bit eb, input bit ed, input bit ez, input bit ee);
        n_vec++;
        if (state !== 2'(es) || heat !== 2'(eh) || time_left !== 12'(el) || tgt_out !== 10'(et) ||
            busy !== eb || done !== ed || buzzer !== ez || start_err !== ee) begin
            n_bad++;
            $display("FAIL %s: got state=%0d heat=%0d left=%0d tgt=%0d busy=%b done=%b buzzer=%b err=%b; want state=%0d heat=%0d left=%0d tgt=%0d busy=%b done=%b buzzer=%b err=%b",
                     name, state, heat, time_left, tgt_out, busy, done, buzzer, start_err,
                     es, eh, el, et, eb, ed, ez, ee);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_state, m_heat, m_left, m_tgt, m_alarm;
    bit m_done, m_err;

    function automatic int heat_for(int tgt, int cur);
        int e = tgt - cur;
        if (e > 20) return 3;
        if (e > 5) return 2;
        if (e > 0) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int nxt;
        int tg, bk, cu;
        bit dr;
        dr = door_open;
        tg = int'(target_temp); bk = int'(bake_time); cu = int'(current_temp);
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_state = 0; m_heat = 0; m_left = 0; m_tgt = 0; m_alarm = 0;
            return;
        end
        nxt = m_state;
        if (cancel) begin
            if (m_state != 0) begin
                nxt = 0;
                m_left = 0;
            end
        end else if (m_state == 0) begin
            if (start) begin
                if (tg >= 150 && tg <= 500 && bk != 0 && !dr) begin
                    nxt = 1;
                    m_left = bk;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_state == 1) begin
            if (!dr && preheated) nxt = 2;
        end else if (m_state == 2) begin
            if (!dr && tick_1hz) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    nxt = 3;
                    m_done = 1;
                    m_alarm = 0;
                end
            end
        end else begin
            if (tick_1hz) begin
                m_alarm++;
                if (m_alarm == DONE_SECS) nxt = 0;
            end
        end
        if ((m_state == 1 || m_state == 2) && (nxt == 1 || nxt == 2) && !dr)
            m_heat = heat_for(m_tgt, cu);
        else
            m_heat = 0;
        if (m_state == 0 && nxt == 1) m_tgt = tg;
        m_state = nxt;
    endtask

    initial begin
        bit found;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //          r s c t p  tgt bake cur   st ht left tgt  busy done buz err
        tbl.push_back(mk(1,0,0,0,0,   0,  0,   0,  0, 0, 0,   0,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 350,  3, 300,  1, 0, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 300,  1, 3, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 340,  1, 2, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 348,  1, 1, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 352,  1, 0, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 330,  1, 2, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0, 349,  2, 1, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 200,  9, 351,  2, 0, 3, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 345,  2, 1, 2, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 320,  2, 3, 1, 350,  1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 300,  3, 0, 0, 350,  1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 300,  3, 0, 0, 350,  1,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 300,  3, 0, 0, 350,  1,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 300,  3, 0, 0, 350,  1,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 300,  0, 0, 0, 350,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 100,  5, 300,  0, 0, 0, 350,  0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,   0,  0, 300,  0, 0, 0, 350,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 400,  0, 300,  0, 0, 0, 350,  0,0,0,1));
        tbl.push_back(mk(0,1,0,0,0, 501,  5, 300,  0, 0, 0, 350,  0,0,0,1));
        tbl.push_back(mk(0,1,0,0,0, 500,  7, 500,  1, 0, 7, 500,  1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,   0,  0, 100,  0, 0, 0, 500,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 150,  5, 100,  1, 0, 5, 150,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0, 100,  2, 3, 5, 150,  1,0,0,0));
        tbl.push_back(mk(0,0,1,1,0,   0,  0, 100,  0, 0, 0, 150,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 200,  1, 200,  1, 0, 1, 200,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,   0,  0, 200,  2, 0, 1, 200,  1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,   0,  0, 200,  3, 0, 0, 200,  1,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,   0,  0, 200,  0, 0, 0,   0,  0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,   0,  0, 200,  0, 0, 0,   0,  0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 149,  5, 200,  0, 0, 0,   0,  0,0,0,1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].t, tbl[i].p, 1'b0,
                  tbl[i].tg, tbl[i].bk, tbl[i].cu);
            @(negedge clk);
            check($sformatf("row%0d", i), tbl[i].es, tbl[i].eh, tbl[i].el, tbl[i].et,
                  tbl[i].eb, tbl[i].ed, tbl[i].ez, tbl[i].ee);
        end

        // Bounded wait for the done pulse of a short bake.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 300);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 300, 4, 300);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 300);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 300);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL done_wait: got no done pulse within 40 cycles, want one");
        end

`ifdef OVEN_DOOR_INTERLOCK_EN
        // Door interlock: freeze the countdown and heat while open.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 300);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 350, 6, 300);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 300);
        @(negedge clk);
        check("door_bake", 2, 3, 6, 350, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 300);
        @(negedge clk);
        @(negedge clk);
        check("door_left4", 2, 3, 4, 350, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0, 0, 300);
        @(negedge clk);
        @(negedge clk);
        check("door_frozen", 2, 0, 4, 350, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 300);
        @(negedge clk);
        check("door_resume", 2, 3, 3, 350, 1, 0, 0, 0);
`endif

        // Randomized run against the behavioural model.
        for (int c = 0; c < 2500; c++) begin
            int cu;
            bit d;
            cu = m_tgt + int'($urandom_range(0, 60)) - 35;
            if (cu < 0) cu = 0;
`ifdef OVEN_DOOR_INTERLOCK_EN
            d = ($urandom_range(0, 7) == 0);
`else
            d = 1'b0;
`endif
            drive((c == 0) || ($urandom_range(0, 299) == 0),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  d,
                  int'($urandom_range(120, 530)),
                  int'($urandom_range(0, 5)),
                  cu);
            model_step();
            @(negedge clk);
            check($sformatf("rand%0d", c), m_state, m_heat, m_left, m_tgt,
                  m_state != 0, m_done, m_state == 3, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
